// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial (LSB-first) WIDTH-bit subtractor with borrow and
//            two's-complement overflow, valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] xs_q,     xs_d;
    logic [WIDTH-1:0] ys_q,     ys_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             brw_q,    brw_d;
    logic             xm_q,     xm_d;
    logic             ym_q,     ym_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic             w_xi;
    logic             w_yi;
    logic             w_diff;
    logic             w_brw;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_res;

    // One full-subtractor bit; the concat form keeps the shift legal at WIDTH=1.
    assign w_xi    = xs_q[0];
    assign w_yi    = ys_q[0];
    assign w_diff  = w_xi ^ w_yi ^ brw_q;
    assign w_brw   = (~w_xi & w_yi) | (~(w_xi ^ w_yi) & brw_q);
    assign w_shift = {w_diff, res_q};
    assign w_res   = w_shift[WIDTH:1];

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xs_d    = x;
                    ys_d    = y;
                    xm_d    = x[WIDTH-1];
                    ym_d    = y[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    brw_d   = b_in;
                    state_d = CALC;
                end
            end
            CALC: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                res_d = w_res;
                brw_d = w_brw;
                cnt_d = cnt_q + CW'(1);
                // Published outputs only change here, so they hold through IDLE/CALC.
                if (cnt_q == C_LAST) begin
                    dout_d  = w_res;
                    bout_d  = w_brw;
                    ovf_d   = (xm_q != ym_q) && (w_res[WIDTH-1] != xm_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            xm_q    <= 1'b0;
            ym_q    <= 1'b0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = dout_q;
    assign b_out     = bout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    // Reference: integer arithmetic, result packed as {d, b_out, ovf}.
    function automatic logic [5:0] model(input logic [3:0] ax, input logic [3:0] ay, input logic ab);
        int ux, uy, sx, sy, ur, sr;
        logic [3:0] rd;
        logic       rb, ro;
        ux = ax; uy = ay;
        sx = (ux >= 8) ? ux - 16 : ux;
        sy = (uy >= 8) ? uy - 16 : uy;
        ur = ux - uy - int'(ab);
        sr = sx - sy - int'(ab);
        rd = 4'((ur + 32) % 16);
        rb = (ur < 0);
        ro = (sr < -8) || (sr > 7);
        return {rd, rb, ro};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents operands for one accept edge, then scrambles inputs while the
    // calculation runs; lat = edges after the accept edge until out_valid.
    task automatic do_op(input logic [3:0] ax, input logic [3:0] ay, input logic ab, output int lat);
        in_valid = 1'b1; x = ax; y = ay; b_in = ab;
        tick();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            x = 4'($urandom); y = 4'($urandom); b_in = 1'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        x = 4'h7; y = 4'h3; b_in = 1'b0;
        tick(); tick();
        reset = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, d, b_out, ovf} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b d=%h b=%b o=%b, want rdy=1 vld=0 d=0 b=0 o=0",
                     in_ready, out_valid, d, b_out, ovf);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] vx [5] = '{4'h7, 4'h3, 4'h0, 4'h8, 4'h7};
        logic [3:0] vy [5] = '{4'h3, 4'h7, 4'h0, 4'h1, 4'hF};
        logic       vb [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 25; i++) begin
            logic [3:0] ax, ay;
            logic       ab;
            logic [5:0] exp;
            int         lat;
            if (i < 5) begin
                ax = vx[i]; ay = vy[i]; ab = vb[i];
            end else begin
                ax = 4'($urandom); ay = 4'($urandom); ab = 1'($urandom);
            end
            exp = model(ax, ay, ab);
            do_op(ax, ay, ab, lat);
            // Counting the accept edge as edge 1, out_valid arrives on edge WIDTH+1.
            n_checks++;
            if (lat != WIDTH) begin
                n_fail++;
                $display("FAIL latency[%0d]: got %0d edges after accept, want %0d", i, lat, WIDTH);
            end
            n_checks++;
            if ({d, b_out, ovf} !== exp) begin
                n_fail++;
                $display("FAIL result[%0d] %h-%h-%b: got d=%h b=%b o=%b, want d=%h b=%b o=%b",
                         i, ax, ay, ab, d, b_out, ovf, exp[5:2], exp[1], exp[0]);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL done_in_ready[%0d]: got %b, want 0", i, in_ready);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL release[%0d]: got vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        logic [5:0] exp;
        int         lat;
        exp = model(4'h8, 4'h1, 1'b0);
        do_op(4'h8, 4'h1, 1'b0, lat);
        for (int c = 0; c < 10; c++) begin
            x = 4'($urandom); y = 4'($urandom); b_in = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            n_checks++;
            if ({out_valid, in_ready, d, b_out, ovf} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b d=%h b=%b o=%b, want vld=1 rdy=0 d=%h b=%b o=%b",
                         c, out_valid, in_ready, d, b_out, ovf, exp[5:2], exp[1], exp[0]);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_abort();
        int lat;
        logic seen;
        in_valid = 1'b1; x = 4'h9; y = 4'h3; b_in = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, d, b_out, ovf} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_state: got rdy=%b vld=%b d=%h b=%b o=%b, want rdy=1 vld=0 d=0 b=0 o=0",
                     in_ready, out_valid, d, b_out, ovf);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen |= out_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_result: out_valid seen=%b, want 0", seen);
        end
        do_op(4'h5, 4'h2, 1'b0, lat);
        n_checks++;
        if (lat != WIDTH || d !== 4'h3 || b_out !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: got lat=%0d d=%h b=%b o=%b, want lat=%0d d=3 b=0 o=0",
                     lat, d, b_out, ovf, WIDTH);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] q[$];
        int idx, got, cyc, last_cyc;
        idx = 0; got = 0; cyc = 0; last_cyc = -1;
        out_ready = 1'b1; in_valid = 1'b1;
        {x, y, b_in} = 9'(idx);
        while (got < 512 && cyc < 512 * 8 + 50) begin
            if (out_valid === 1'b1) begin
                logic [5:0] exp;
                exp = (q.size() > 0) ? q.pop_front() : 6'bx;
                n_checks++;
                if ({d, b_out, ovf} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got d=%h b=%b o=%b, want d=%h b=%b o=%b",
                             got, d, b_out, ovf, exp[5:2], exp[1], exp[0]);
                end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_cyc != WIDTH + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval[%0d]: got %0d cycles, want %0d", got, cyc - last_cyc, WIDTH + 2);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (in_ready === 1'b1 && idx < 512) begin
                q.push_back(model(x, y, b_in));
                tick();
                idx++;
                {x, y, b_in} = 9'(idx);
                if (idx == 512) in_valid = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        n_checks++;
        if (got != 512) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, want 512", got);
        end
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
